// File: rtl/bram_dma_copier.sv
// Byte-at-a-time memmove engine driving one single-port BRAM through its cs/we/dr handshake.
// Direction is chosen at start so overlapping source/destination ranges copy correctly.
module bram_dma_copier #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  input  logic              ram_dr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WRITE, S_GAP, S_DONE
  } state_t;

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_src, w_src;
  logic [ADDR_W-1:0]   r_dst, w_dst;
  logic [ADDR_W:0]     r_rem, w_rem;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [DATA_W-1:0]   r_data, w_data;
  logic                r_desc, w_desc;
  logic                r_err, w_err;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_cs, w_cs;
  logic                r_we, w_we;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_dout, w_dout;
  logic [ADDR_W-1:0]   w_diff;

  assign w_diff = dst_addr - src_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_desc  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state;
      r_src   <= w_src;
      r_dst   <= w_dst;
      r_rem   <= w_rem;
      r_cnt   <= w_cnt;
      r_data  <= w_data;
      r_desc  <= w_desc;
      r_err   <= w_err;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cs    <= w_cs;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_dout  <= w_dout;
    end
  end

  always_comb begin
    w_state = r_state;
    w_src   = r_src;
    w_dst   = r_dst;
    w_rem   = r_rem;
    w_cnt   = r_cnt;
    w_data  = r_data;
    w_desc  = r_desc;
    w_err   = r_err;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_err  = 1'b0;
          w_rem  = len;
          w_desc = ({1'b0, w_diff} < len);
          // Descending copies start at the top of both ranges.
          if (w_desc) begin
            w_src = src_addr + len[ADDR_W-1:0] - ADDR_W'(1);
            w_dst = dst_addr + len[ADDR_W-1:0] - ADDR_W'(1);
          end else begin
            w_src = src_addr;
            w_dst = dst_addr;
          end
          w_state = (len == '0 || src_addr == dst_addr) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        w_cnt   = '0;
        w_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (ram_dr) begin
          w_data  = ram_din;
          w_state = S_WRITE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_WRITE: begin
        w_src   = r_desc ? r_src - ADDR_W'(1) : r_src + ADDR_W'(1);
        w_dst   = r_desc ? r_dst - ADDR_W'(1) : r_dst + ADDR_W'(1);
        w_rem   = r_rem - (ADDR_W+1)'(1);
        w_state = (w_rem == '0) ? S_DONE : S_GAP;
      end
      S_GAP:   w_state = S_RD_REQ;
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    if (abort && r_state != S_IDLE && r_state != S_DONE) begin
      w_err   = 1'b1;
      w_state = S_DONE;
    end

    // Bus outputs are registered from the next state so they line up with it.
    w_cs   = (w_state == S_RD_REQ) || (w_state == S_RD_WAIT) || (w_state == S_WRITE);
    w_we   = (w_state == S_WRITE);
    w_addr = (w_state == S_WRITE) ? w_dst : (w_cs ? w_src : r_addr);
    w_dout = (w_state == S_WRITE) ? w_data : r_dout;
    w_done = (w_state == S_DONE);
    w_busy = (w_state != S_IDLE);
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign ram_cs   = r_cs;
  assign ram_we   = r_we;
  assign ram_addr = r_addr;
  assign ram_dout = r_dout;

endmodule

// File: tb/tb_bram_dma_copier.sv
// Self-checking bench: BRAM model plus a memmove reference model with expected bus/timing traces.
module tb_bram_dma_copier;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [16:0] len = '0;
  logic        busy, done, err, ram_cs, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        ram_dr = 1'b0;
  logic        stall = 1'b0;

  logic [7:0]  mem   [0:65535];
  logic [7:0]  model [0:65535];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_done = 0;
  int done_seen = -1;
  bit active = 1'b0;
  bit exp_err = 1'b0;
  logic prev_cs = 1'b0;
  logic [15:0] exp_rd[$];
  logic [15:0] obs_rd[$];
  logic [23:0] exp_wr[$];

  bram_dma_copier #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_din(ram_din), .ram_dr(ram_dr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Zero-wait BRAM; stall suppresses data-ready entirely.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_dout;
      else if (!stall) begin
        ram_din <= mem[ram_addr];
        ram_dr  <= 1'b1;
      end
    end else begin
      ram_dr <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s actual=%h required=none", nm, act);
  endtask

  always @(negedge clk) begin
    int rel;
    logic [23:0] e;
    logic [15:0] ra;
    rel = cyc - start_cyc;
    if (active && rel >= 1) begin
      chk("done", 32'(done), 32'(rel == exp_done));
      chk("busy", 32'(busy), 32'(rel <= exp_done));
      if (rel == 1) chk("err_cleared", 32'(err), 32'd0);
      if (rel == exp_done) chk("err", 32'(err), 32'(exp_err));
      if (rel >= exp_done) chk("cs_low", 32'(ram_cs), 32'd0);
      if (done === 1'b1 && done_seen < 0) done_seen = rel;
      if (ram_cs && ram_we) begin
        if (exp_wr.size() == 0) unexpected("extra_write", {8'd0, ram_addr, ram_dout});
        else begin
          e = exp_wr.pop_front();
          chk("write", {8'd0, ram_addr, ram_dout}, {8'd0, e});
        end
      end
      if (ram_cs && !ram_we && !prev_cs) begin
        obs_rd.push_back(ram_addr);
        if (exp_rd.size() == 0) unexpected("extra_read", {16'd0, ram_addr});
        else begin
          ra = exp_rd.pop_front();
          chk("read_addr", {16'd0, ram_addr}, {16'd0, ra});
        end
      end
    end
    prev_cs = ram_cs;
  end

  task automatic put(input logic [15:0] a, input logic [7:0] v);
    mem[a] = v;
    model[a] = v;
  endtask

  task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [16:0] l,
                     input bit stl, input int ak);
    int full, nr, nw, nbad;
    bit desc;
    logic [7:0]  data[$];
    logic [15:0] off[$];
    logic [15:0] o;
    full = (l == 0 || s == d) ? 0 : int'(l);
    desc = ({1'b0, 16'(d - s)} < l);
    if (full == 0) begin
      exp_done = 1; exp_err = 1'b0; nr = 0; nw = 0;
    end else if (stl) begin
      exp_done = 2 + TO; exp_err = 1'b1; nr = 1; nw = 0;
    end else if (ak > 0 && ak < 4 * full) begin
      exp_done = ak + 1; exp_err = 1'b1;
      nr = (ak - 1) / 4 + 1;
      nw = (ak >= 3) ? (ak - 3) / 4 + 1 : 0;
    end else begin
      exp_done = 4 * full; exp_err = 1'b0; nr = full; nw = full;
    end
    exp_rd.delete(); exp_wr.delete(); obs_rd.delete();
    for (int i = 0; i < full; i++) begin
      o = desc ? 16'(full - 1 - i) : 16'(i);
      off.push_back(o);
      data.push_back(model[16'(s + o)]);
    end
    for (int i = 0; i < nr; i++) exp_rd.push_back(16'(s + off[i]));
    for (int i = 0; i < nw; i++) begin
      exp_wr.push_back({16'(d + off[i]), data[i]});
      model[16'(d + off[i])] = data[i];
    end

    @(negedge clk); #1;
    src_addr = s; dst_addr = d; len = l; stall = stl;
    start_cyc = cyc; done_seen = -1; active = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc - start_cyc <= exp_done + 1) begin
      @(negedge clk); #1;
      abort = (ak > 0 && (cyc - start_cyc) == ak);
    end
    abort = 1'b0; active = 1'b0; stall = 1'b0;
    chk("done_cycle", 32'(done_seen), 32'(exp_done));
    chk("reads_left", 32'(exp_rd.size()), 32'd0);
    chk("writes_left", 32'(exp_wr.size()), 32'd0);
    nbad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== model[a]) nbad++;
    chk("mem_image", 32'(nbad), 32'd0);
  endtask

  initial begin
    logic [15:0] s, d, wrap_rd[4];
    logic [16:0] l;
    bit stl;
    int ak;
    logic [7:0] v;
    for (int a = 0; a < 65536; a++) begin
      v = 8'($urandom);
      mem[a] = v;
      model[a] = v;
    end
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cs", 32'(ram_cs), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr_dout", {8'd0, ram_addr, ram_dout}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    put(16'h0100, 8'h11); put(16'h0101, 8'h22); put(16'h0102, 8'h33); put(16'h0103, 8'h44);
    run(16'h0100, 16'h0200, 17'd4, 1'b0, 0);
    chk("t1_b0", 32'(mem[16'h0200]), 32'h11);
    chk("t1_b1", 32'(mem[16'h0201]), 32'h22);
    chk("t1_b2", 32'(mem[16'h0202]), 32'h33);
    chk("t1_b3", 32'(mem[16'h0203]), 32'h44);
    chk("t1_done_cycle", 32'(done_seen), 32'd16);

    put(16'h0010, 8'hAA); put(16'h0011, 8'hBB); put(16'h0012, 8'hCC); put(16'h0013, 8'hDD);
    run(16'h0010, 16'h0012, 17'd4, 1'b0, 0);
    chk("t2_b0", 32'(mem[16'h0012]), 32'hAA);
    chk("t2_b1", 32'(mem[16'h0013]), 32'hBB);
    chk("t2_b2", 32'(mem[16'h0014]), 32'hCC);
    chk("t2_b3", 32'(mem[16'h0015]), 32'hDD);
    chk("t2_first_read", (obs_rd.size() > 0) ? {16'd0, obs_rd[0]} : 32'hFFFF_FFFF, 32'h13);

    run(16'hFFFE, 16'h0010, 17'd4, 1'b0, 0);
    wrap_rd[0] = 16'hFFFE; wrap_rd[1] = 16'hFFFF; wrap_rd[2] = 16'h0000; wrap_rd[3] = 16'h0001;
    chk("t3_nreads", 32'(obs_rd.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_read", (obs_rd.size() > i) ? {16'd0, obs_rd[i]} : 32'hFFFF_FFFF, {16'd0, wrap_rd[i]});

    run(16'h0500, 16'h0600, 17'd3, 1'b1, 0);
    chk("t4_done_cycle", 32'(done_seen), 32'd17);
    chk("t4_nreads", 32'(obs_rd.size()), 32'd1);

    for (int i = 0; i < 8; i++) begin
      put(16'(16'h0300 + i), 8'(8'h5A + i));
      put(16'(16'h0400 + i), 8'h00);
    end
    run(16'h0300, 16'h0400, 17'd8, 1'b0, 6);
    chk("t5_done_cycle", 32'(done_seen), 32'd7);
    chk("t5_b0", 32'(mem[16'h0400]), 32'h5A);
    chk("t5_b1", 32'(mem[16'h0401]), 32'h00);

    run(16'h0020, 16'h0030, 17'd0, 1'b0, 0);
    chk("t6_len0_done", 32'(done_seen), 32'd1);
    chk("t6_len0_reads", 32'(obs_rd.size()), 32'd0);
    run(16'h0040, 16'h0040, 17'd5, 1'b0, 0);
    chk("t6_same_done", 32'(done_seen), 32'd1);
    chk("t6_same_reads", 32'(obs_rd.size()), 32'd0);

    for (int n = 0; n < 30; n++) begin
      s = 16'($urandom);
      d = ($urandom_range(0, 1) == 1) ? 16'(s + 16'($urandom_range(0, 20)) - 16'd10) : 16'($urandom);
      l = 17'($urandom_range(0, 12));
      stl = ($urandom_range(0, 7) == 0);
      ak = (!stl && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : 0;
      run(s, d, l, stl, ak);
    end

    @(negedge clk); #1;
    src_addr = 16'h0700; dst_addr = 16'h0800; len = 17'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("pre_reset_cs", 32'(ram_cs), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_cs", 32'(ram_cs), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    run(16'h0700, 16'h0800, 17'd2, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
